phase_readout: RTL and testbench

- Downstream consumer of the coupled-oscillator matrix outputs (the bottom-row horizontal oscillator outputs).
- Synchronizes the N free-running oscillator signals into the clk domain.
- Over a programmable sample window, counts the cycles in which each oscillator is out of phase with oscillator 0 (the reference).
- Resolves each oscillator to a spin bit and exposes counts, spins and status through the same write-strobe register interface used for weight programming, plus a registered read port.

---
 rtl/phase_readout_pkg.sv | 21 ++
 rtl/defines.vh | 20 ++
 rtl/osc_sync.sv | 27 ++
 rtl/phase_readout.sv | 189 ++++++++++++++++++
 tb/tb_phase_readout.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_readout_pkg.sv
// rtl/phase_readout_pkg.sv - state type and register map constants for phase_readout
`include "defines.vh"

package phase_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `READOUT_ST_IDLE,
    ST_CLEAR = `READOUT_ST_CLEAR,
    ST_COUNT = `READOUT_ST_COUNT,
    ST_DONE  = `READOUT_ST_DONE
  } state_e;

  localparam logic [31:0] ADDR_MASK      = `READOUT_ADDR_MASK;
  localparam logic [31:0] ADDR_BASE      = `READOUT_ADDR_BASE;
  localparam logic [11:0] OFF_CTRL       = `READOUT_OFF_CTRL;
  localparam logic [11:0] OFF_WINDOW     = `READOUT_OFF_WINDOW;
  localparam logic [11:0] OFF_SPINS      = `READOUT_OFF_SPINS;
  localparam logic [11:0] OFF_COUNT_BASE = `READOUT_OFF_COUNT_BASE;
  localparam logic [31:0] WINDOW_RST     = `READOUT_WINDOW_RST;

endpackage

// File: rtl/defines.vh
// rtl/defines.vh - shared address map, register offsets and state encodings for phase_readout
`ifndef PHASE_READOUT_DEFINES_VH
`define PHASE_READOUT_DEFINES_VH

`define READOUT_ADDR_MASK      32'hFFFF_F000
`define READOUT_ADDR_BASE      32'h4000_0000

`define READOUT_OFF_CTRL       12'h000
`define READOUT_OFF_WINDOW     12'h004
`define READOUT_OFF_SPINS      12'h008
`define READOUT_OFF_COUNT_BASE 12'h100

`define READOUT_ST_IDLE        2'd0
`define READOUT_ST_CLEAR       2'd1
`define READOUT_ST_COUNT       2'd2
`define READOUT_ST_DONE        2'd3

`define READOUT_WINDOW_RST     32'h0000_0400

`endif

// File: rtl/osc_sync.sv
// rtl/osc_sync.sv - per-bit multi-flop synchronizer for the free-running oscillator outputs
module osc_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/phase_readout.sv
// rtl/phase_readout.sv - windowed phase-mismatch counters and spin resolution against oscillator 0
`include "defines.vh"

module phase_readout
  import phase_readout_pkg::*;
#(
  parameter int N           = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic [N-1:0]  osc_in,
  input  logic          wready,
  input  logic [31:0]   wr_addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  spins
);

  localparam int IDX_W = $clog2(N);

  logic [N-1:0]         osc_s;
  logic [N-1:0]         mismatch;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [CNT_WIDTH-1:0] window_q;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] count_q [N];
  logic [CNT_WIDTH-1:0] count_d [N];
  logic [N-1:0]         spins_q, spins_d;
  logic [31:0]          rd_data_q, rd_data_d;

  logic                 wr_sel, wr_ctrl, start_w, abort_w;
  logic                 clear_cnt, count_en, latch_spins;

  osc_sync #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_osc_sync (
    .clk     (clk),
    .rst_n   (axi_rstn),
    .async_i (osc_in),
    .sync_o  (osc_s)
  );

  // Oscillator 0 is the phase reference, so its own mismatch is forced low.
  assign mismatch = {osc_s[N-1:1] ^ {(N-1){osc_s[0]}}, 1'b0};

  assign wr_sel  = wready && ((wr_addr & ADDR_MASK) == ADDR_BASE);
  assign wr_ctrl = wr_sel && (wr_addr[11:0] == OFF_CTRL);
  assign abort_w = wr_ctrl && wdata[1];
  assign start_w = wr_ctrl && wdata[0] && !wdata[1];

  assign busy  = (state_q == ST_CLEAR) || (state_q == ST_COUNT);
  assign done  = (state_q == ST_DONE);
  assign spins = spins_q;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      window_q <= CNT_WIDTH'(WINDOW_RST);
    end else begin
      state_q <= state_d;
      start_q <= start_w;
      if (wr_sel && (wr_addr[11:0] == OFF_WINDOW) && !busy) begin
        window_q <= CNT_WIDTH'(wdata);
      end
    end
  end

  // Abort is decoded straight from the write so it takes effect on the next edge;
  // start goes through start_q, which gives the one-cycle control decode latency.
  always_comb begin
    state_d     = state_q;
    clear_cnt   = 1'b0;
    count_en    = 1'b0;
    latch_spins = 1'b0;
    if (abort_w) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_q && (window_q != '0)) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clear_cnt = 1'b1;
          state_d   = ST_COUNT;
        end
        ST_COUNT: begin
          count_en = 1'b1;
          if (cyc_q == window_q - CNT_WIDTH'(1)) begin
            state_d     = ST_DONE;
            latch_spins = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cyc_d = cyc_q;
    if (clear_cnt) begin
      cyc_d = '0;
    end else if (count_en) begin
      cyc_d = cyc_q + CNT_WIDTH'(1);
    end
    for (int i = 0; i < N; i++) begin
      count_d[i] = count_q[i];
      if (clear_cnt) begin
        count_d[i] = '0;
      end else if (count_en && mismatch[i] && (count_q[i] != {CNT_WIDTH{1'b1}})) begin
        count_d[i] = count_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Spins are resolved from the final counts, including the last window cycle.
  always_comb begin
    spins_d = spins_q;
    for (int i = 0; i < N; i++) begin
      if (latch_spins) begin
        spins_d[i] = (count_d[i] > (window_q >> 1));
      end
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cyc_q   <= '0;
      spins_q <= '0;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      cyc_q   <= cyc_d;
      spins_q <= spins_d;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  logic [11:0]      rd_off;
  logic [11:0]      cnt_off;
  logic [IDX_W-1:0] cnt_idx;
  logic             cnt_hit;

  assign rd_off  = rd_addr[11:0];
  assign cnt_off = rd_off - OFF_COUNT_BASE;
  assign cnt_idx = cnt_off[IDX_W+1:2];
  assign cnt_hit = (rd_off >= OFF_COUNT_BASE) && (cnt_off < 12'(4 * N)) &&
                   (rd_off[1:0] == 2'b00);

  always_comb begin
    rd_data_d = '0;
    if (rd_off == OFF_CTRL) begin
      rd_data_d = {30'b0, done, busy};
    end else if (rd_off == OFF_WINDOW) begin
      rd_data_d = 32'(window_q);
    end else if (rd_off == OFF_SPINS) begin
      rd_data_d = 32'(spins_q);
    end else if (cnt_hit) begin
      rd_data_d = 32'(count_q[cnt_idx]);
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

  logic unused_bits;
  assign unused_bits = ^{rd_addr[31:12], wdata, cnt_off};

endmodule

// File: tb/tb_phase_readout.sv
// tb/tb_phase_readout.sv - scoreboard bench for phase_readout
module tb_phase_readout;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        axi_rstn;
  logic [7:0]  osc_in = '0;
  logic        wready;
  logic [31:0] wr_addr, wdata, rd_addr;
  logic [31:0] rd_data, rd_data8;
  logic        busy, done, busy8, done8;
  logic [7:0]  spins, spins8;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int mode = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          sel8;
  } rd_exp_t;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  phase_readout #(.N(8), .CNT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .osc_in(osc_in), .wready(wready),
    .wr_addr(wr_addr), .wdata(wdata), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .spins(spins)
  );

  phase_readout #(.N(8), .CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .axi_rstn(axi_rstn), .osc_in(osc_in), .wready(wready),
    .wr_addr(wr_addr), .wdata(wdata), .rd_addr(rd_addr), .rd_data(rd_data8),
    .busy(busy8), .done(done8), .spins(spins8)
  );

  function automatic logic [7:0] pattern(int m, int t);
    logic a0, a1, sq;
    sq = t[3];
    a0 = (t % 8) < 4;
    case (m)
      1: return {{4{~sq}}, {4{sq}}};
      2: begin a1 = ((t + 6) % 8) < 4; return {{6{a0}}, a1, a0}; end
      3: begin a1 = ((t + 5) % 8) < 4; return {{6{a0}}, a1, a0}; end
      4: return 8'b0000_0010;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    #2;
    osc_in = pattern(mode, tick);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit en = 1'b1);
    @(negedge clk);
    wready  = en;
    wr_addr = addr;
    wdata   = data;
    @(negedge clk);
    wready  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input bit sel8, input logic [31:0] addr,
                          input logic [31:0] exp);
    rd_exp_t e;
    @(negedge clk);
    rd_addr = addr;
    sb.push_back('{tag, exp, sel8});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, e.sel8 ? rd_data8 : rd_data, e.exp);
  endtask

  task automatic rd_range(input string tag, input logic [31:0] addr, input int lo, input int hi);
    @(negedge clk);
    rd_addr = addr;
    @(posedge clk);
    #1;
    check(tag, 32'((int'(rd_data) >= lo) && (int'(rd_data) <= hi)), 32'd1);
  endtask

  task automatic wait_done(input int t0, input bit sel8, input int limit, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (sel8 ? done8 : done) begin
        lat = tick - t0;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, lat;
    axi_rstn = 1'b0;
    wready   = 1'b0;
    wr_addr  = '0;
    wdata    = '0;
    rd_addr  = '0;
    repeat (3) @(negedge clk);
    axi_rstn = 1'b1;

    // reset mid-run
    mode = 1;
    repeat (4) @(negedge clk);
    wr(BASE, 32'h1);
    repeat (50) @(negedge clk);
    check("t1_busy_running", busy, 1);
    #2 axi_rstn = 1'b0;
    #1;
    check("t1_busy_async", busy, 0);
    check("t1_done_async", done, 0);
    check("t1_spins_async", spins, 0);
    @(negedge clk);
    axi_rstn = 1'b1;
    rd_check("t1_rd_ctrl", 0, BASE + 32'h000, 32'h0);
    rd_check("t1_rd_window", 0, BASE + 32'h004, 32'h400);
    rd_check("t1_rd_spins", 0, BASE + 32'h008, 32'h0);
    rd_check("t1_rd_count4", 0, BASE + 32'h110, 32'h0);

    // in-phase vs anti-phase
    wr(BASE + 32'h4, 32'd100);
    wr(BASE, 32'h1);
    t0 = tick;
    wait_done(t0, 0, 2000, lat);
    check("t2_done_latency", 32'(lat), 32'd102);
    check("t2_busy_low", busy, 0);
    check("t2_spins", spins, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      rd_check($sformatf("t2_count%0d", i), 0, BASE + 32'h100 + 32'(4 * i), (i >= 4) ? 32'd100 : 32'd0);
    end
    rd_check("t2_rd_spins", 0, BASE + 32'h008, 32'hF0);
    rd_check("t2_rd_ctrl", 0, BASE + 32'h000, 32'h2);

    // quarter and three-eighths lag
    mode = 2;
    wr(BASE + 32'h4, 32'd64);
    repeat (4) @(negedge clk);
    wr(BASE, 32'h1);
    t0 = tick;
    wait_done(t0, 0, 2000, lat);
    check("t3_latency", 32'(lat), 32'd66);
    rd_check("t3_count1_quarter", 0, BASE + 32'h104, 32'd32);
    check("t3_spins_quarter", spins, 8'h00);
    mode = 3;
    repeat (4) @(negedge clk);
    wr(BASE, 32'h1);
    t0 = tick;
    wait_done(t0, 0, 2000, lat);
    rd_check("t3_count1_3_8", 0, BASE + 32'h104, 32'd48);
    rd_check("t3_count2_3_8", 0, BASE + 32'h108, 32'd0);
    check("t3_spins_3_8", spins, 8'h02);

    // control edge cases
    wr(BASE + 32'h4, 32'd0);
    rd_check("t4_window_zero", 0, BASE + 32'h004, 32'h0);
    wr(BASE, 32'h1);
    repeat (4) @(negedge clk);
    check("t4_zero_start_busy", busy, 0);
    check("t4_zero_start_done", done, 1);
    wr(BASE + 32'h4, 32'd20);
    wr(BASE, 32'h1);
    t0 = tick;
    wr(BASE, 32'h1);
    wr(BASE + 32'h4, 32'd7);
    wait_done(t0, 0, 200, lat);
    check("t4_restart_ignored", 32'(lat), 32'd22);
    rd_check("t4_window_locked", 0, BASE + 32'h004, 32'd20);
    wr(BASE, 32'h1);
    repeat (3) @(negedge clk);
    check("t4_busy_before_abort", busy, 1);
    wr(BASE, 32'h3);
    check("t4_start_abort_busy", busy, 0);
    check("t4_start_abort_done", done, 0);
    repeat (5) @(negedge clk);
    check("t4_no_restart", busy, 0);
    wr(BASE + 32'h4, 32'd55, 1'b0);
    rd_check("t4_wready_low", 0, BASE + 32'h004, 32'd20);
    wr(32'h5000_0004, 32'd77);
    rd_check("t4_wrong_base", 0, BASE + 32'h004, 32'd20);

    // abort mid-run
    mode = 1;
    wr(BASE + 32'h4, 32'd1000);
    wr(BASE, 32'h1);
    t0 = tick;
    while (tick < t0 + 498) @(negedge clk);
    wr(BASE, 32'h2);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    rd_range("t5_count4_near", BASE + 32'h110, 495, 500);
    repeat (20) @(negedge clk);
    rd_range("t5_count4_frozen", BASE + 32'h110, 495, 500);
    mode = 0;
    repeat (4) @(negedge clk);
    wr(BASE, 32'h1);
    repeat (8) @(negedge clk);
    wr(BASE, 32'h2);
    rd_check("t5_count4_recleared", 0, BASE + 32'h110, 32'd0);

    // saturation width and read map
    mode = 4;
    repeat (4) @(negedge clk);
    wr(BASE + 32'h4, 32'd255);
    wr(BASE, 32'h1);
    t0 = tick;
    wait_done(t0, 1, 2000, lat);
    check("t6_latency8", 32'(lat), 32'd257);
    rd_check("t6_count1_sat", 1, BASE + 32'h104, 32'hFF);
    check("t6_spins8", spins8, 8'h02);
    rd_check("t6_rd_spins", 0, BASE + 32'h008, 32'h02);
    rd_check("t6_beyond_n", 0, BASE + 32'h124, 32'h0);
    rd_check("t6_unmapped", 0, BASE + 32'h00C, 32'h0);
    rd_check("t6_seq_window", 0, BASE + 32'h004, 32'hFF);
    rd_check("t6_seq_count1", 0, BASE + 32'h104, 32'hFF);
    rd_check("t6_seq_ctrl", 0, BASE + 32'h000, 32'h2);
    rd_check("t6_seq_count0", 0, BASE + 32'h100, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
